// File: rtl/comp_checker_if.sv
// -----------------------------------------------------------------------------
// comp_checker_if
//
// Purpose : groups the signals between the fingerprint comparison checker and
//           its environment (fingerprint-ready flags, pointer compare flags,
//           tail pointers, the RAM read ports, the reset-request handshake and
//           the mismatch interrupt).
//
// Modports:
//   master : the comparison checker (drives task select, tail increment,
//            reset request, RAM addresses, interrupt and mismatch reporting).
//   slave  : the surrounding fingerprint unit / peer logic.
//
// Widths come from the crc_defines.v macros; the fallbacks below apply only
// when that file has not been compiled ahead of this one.
// -----------------------------------------------------------------------------
`ifndef CRC_KEY_SIZE
`define CRC_KEY_SIZE 16
`endif
`ifndef CRC_KEY_WIDTH
`define CRC_KEY_WIDTH 4
`endif
`ifndef CRC_RAM_ADDRESS_WIDTH
`define CRC_RAM_ADDRESS_WIDTH 8
`endif

interface comp_checker_if;
  logic [`CRC_KEY_SIZE-1:0]          fprints_ready_in;
  logic                              head0_matches_head1;
  logic                              tail0_matches_head0;
  logic                              tail1_matches_head1;
  logic [`CRC_RAM_ADDRESS_WIDTH-1:0] comp_tail_pointer0;
  logic [`CRC_RAM_ADDRESS_WIDTH-1:0] comp_tail_pointer1;
  logic [`CRC_KEY_WIDTH-1:0]         comp_task;
  logic                              comp_increment_tail_pointer;
  logic                              comp_reset_fprint_ready;
  logic                              reset_fprint_ack;
  logic                              comp_mismatch_detected;
  logic [`CRC_RAM_ADDRESS_WIDTH-1:0] ram_addr0;
  logic [`CRC_RAM_ADDRESS_WIDTH-1:0] ram_addr1;
  logic [31:0]                       ram_data0;
  logic [31:0]                       ram_data1;
  logic                              irq_clear;
  logic                              comp_irq;
  logic [`CRC_KEY_WIDTH-1:0]         mismatch_task;
  logic [7:0]                        mismatch_count;

  modport master (
    input  fprints_ready_in, head0_matches_head1, tail0_matches_head0,
           tail1_matches_head1, comp_tail_pointer0, comp_tail_pointer1,
           reset_fprint_ack, ram_data0, ram_data1, irq_clear,
    output comp_task, comp_increment_tail_pointer, comp_reset_fprint_ready,
           comp_mismatch_detected, ram_addr0, ram_addr1, comp_irq,
           mismatch_task, mismatch_count
  );

  modport slave (
    output fprints_ready_in, head0_matches_head1, tail0_matches_head0,
           tail1_matches_head1, comp_tail_pointer0, comp_tail_pointer1,
           reset_fprint_ack, ram_data0, ram_data1, irq_clear,
    input  comp_task, comp_increment_tail_pointer, comp_reset_fprint_ready,
           comp_mismatch_detected, ram_addr0, ram_addr1, comp_irq,
           mismatch_task, mismatch_count
  );
endinterface

// File: rtl/comp_checker.sv
// -----------------------------------------------------------------------------
// comp_checker
//
// Purpose : picks a task whose fingerprints are ready on both cores
//           (round-robin), walks both fingerprint queues from their tails,
//           compares entry pairs read from the two fingerprint RAMs, advances
//           both tails on every matching pair and finally asks the peer to
//           reset the task's ready flag, flagging whether a mismatch was seen.
//           An acknowledged mismatch raises comp_irq and records the task.
//
// Ports   :
//   clk   - system clock, rising edge
//   reset - asynchronous, active-high reset
//   cif   - comp_checker_if.master (ready flags, pointer compares, tail
//           pointers, RAM ports, reset handshake, irq / mismatch reporting)
//
// Option  : define COMP_MISMATCH_COUNT_EN to get a saturating 8-bit count of
//           acknowledged mismatches on mismatch_count; otherwise it is tied 0.
// -----------------------------------------------------------------------------
`ifndef CRC_KEY_SIZE
`define CRC_KEY_SIZE 16
`endif
`ifndef CRC_KEY_WIDTH
`define CRC_KEY_WIDTH 4
`endif
`ifndef CRC_RAM_ADDRESS_WIDTH
`define CRC_RAM_ADDRESS_WIDTH 8
`endif

module comp_checker (
  input  logic          clk,
  input  logic          reset,
  comp_checker_if.master cif
);

  localparam int KS = `CRC_KEY_SIZE;
  localparam int KW = `CRC_KEY_WIDTH;
  localparam int AW = `CRC_RAM_ADDRESS_WIDTH;

  typedef enum logic [2:0] {
    IDLE, SEL_WAIT, CHECK, RD, CMP, TAIL_WAIT, RESET_REQ
  } state_e;

  state_e          state_q, state_d;
  logic            wait_q, wait_d;        // second cycle of a 2-cycle wait
  logic [KW-1:0]   task_q, task_d;
  logic [KW-1:0]   last_q, last_d;        // last serviced task
  logic            mm_q, mm_d;            // mismatch flag for this task
  logic [AW-1:0]   addr0_q, addr0_d;
  logic [AW-1:0]   addr1_q, addr1_d;
  logic            incr_q, incr_d;
  logic            irq_q, irq_d;
  logic [KW-1:0]   mtask_q, mtask_d;
  logic            mm_ack;                // mismatch request acknowledged

  logic            pick_valid;
  logic [KW-1:0]   pick_task;
  logic [KW-1:0]   scan_idx;

  // The head-vs-head compare is not needed to decide anything here: the
  // per-core tail-vs-head flags alone say whether a queue is exhausted.
  logic unused_head_cmp;
  assign unused_head_cmp = cif.head0_matches_head1;

  // Round-robin pick: scan from last_q+1 upwards, wrapping at KS; the last
  // iteration wraps back onto last_q itself.
  always_comb begin
    // NOTE: every variable gets a default first so no path infers a latch.
    pick_valid = 1'b0;
    pick_task  = last_q;
    scan_idx   = '0;
    for (int i = 1; i <= KS; i++) begin
      scan_idx = last_q + KW'(i);
      if (!pick_valid && cif.fprints_ready_in[scan_idx]) begin
        pick_valid = 1'b1;
        pick_task  = scan_idx;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    task_d  = task_q;
    last_d  = last_q;
    mm_d    = mm_q;
    addr0_d = addr0_q;
    addr1_d = addr1_q;
    incr_d  = 1'b0;
    irq_d   = irq_q;
    mtask_d = mtask_q;
    mm_ack  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          task_d  = pick_task;
          last_d  = pick_task;
          mm_d    = 1'b0;
          wait_d  = 1'b0;
          state_d = SEL_WAIT;
        end
      end
      // Two cycles for the registered tail pointers / compare flags of the
      // newly selected task to settle.
      SEL_WAIT, TAIL_WAIT: begin
        if (wait_q) begin
          wait_d  = 1'b0;
          state_d = CHECK;
        end else begin
          wait_d  = 1'b1;
        end
      end
      CHECK: begin
        if (cif.tail0_matches_head0 || cif.tail1_matches_head1) begin
          mm_d    = 1'b0;
          state_d = RESET_REQ;
        end else begin
          addr0_d = cif.comp_tail_pointer0;
          addr1_d = cif.comp_tail_pointer1;
          state_d = RD;
        end
      end
      // Addresses are registered on leaving CHECK, so the RAMs sample them
      // at the end of RD and the data is valid during CMP.
      RD:  state_d = CMP;
      CMP: begin
        if (cif.ram_data0 == cif.ram_data1) begin
          incr_d  = 1'b1;
          wait_d  = 1'b0;
          state_d = TAIL_WAIT;
        end else begin
          mm_d    = 1'b1;
          state_d = RESET_REQ;
        end
      end
      RESET_REQ: begin
        if (cif.reset_fprint_ack) begin
          mm_ack  = mm_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A set in the same cycle as irq_clear wins.
    if (cif.irq_clear) irq_d = 1'b0;
    if (mm_ack) begin
      irq_d   = 1'b1;
      mtask_d = task_q;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      wait_q  <= 1'b0;
      task_q  <= '0;
      last_q  <= KW'(KS - 1);
      mm_q    <= 1'b0;
      addr0_q <= '0;
      addr1_q <= '0;
      incr_q  <= 1'b0;
      irq_q   <= 1'b0;
      mtask_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      task_q  <= task_d;
      last_q  <= last_d;
      mm_q    <= mm_d;
      addr0_q <= addr0_d;
      addr1_q <= addr1_d;
      incr_q  <= incr_d;
      irq_q   <= irq_d;
      mtask_q <= mtask_d;
    end
  end

`ifdef COMP_MISMATCH_COUNT_EN
  logic [7:0] count_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else if (mm_ack && count_q != 8'hFF) begin
      count_q <= count_q + 8'd1;
    end
  end

  assign cif.mismatch_count = count_q;
`else
  assign cif.mismatch_count = '0;
`endif

  assign cif.comp_task                   = task_q;
  assign cif.comp_increment_tail_pointer = incr_q;
  assign cif.comp_reset_fprint_ready     = (state_q == RESET_REQ);
  assign cif.comp_mismatch_detected      = (state_q == RESET_REQ) && mm_q;
  assign cif.ram_addr0                   = addr0_q;
  assign cif.ram_addr1                   = addr1_q;
  assign cif.comp_irq                    = irq_q;
  assign cif.mismatch_task               = mtask_q;

endmodule

// File: doc/comp_checker.md
COMP_CHECKER -- requirements
Module: comp_checker

Interface
REQ-001 SHALL provide: clk  in  1  system clock; all state on rising edge.
REQ-002 SHALL provide: reset  in  1  asynchronous, active-high reset.
REQ-003 SHALL provide: fprints_ready_in  in  CRC_KEY_SIZE  per-task "both cores have fingerprints" flags.
REQ-004 SHALL provide: head0_matches_head1, tail0_matches_head0, tail1_matches_head1  in  1 each  pointer-compare flags for comp_task.
REQ-005 SHALL provide: comp_tail_pointer0/1  in  CRC_RAM_ADDRESS_WIDTH each  registered tail pointers for comp_task.
REQ-006 SHALL provide: comp_task  out  CRC_KEY_WIDTH  task under comparison.
REQ-007 SHALL provide: comp_increment_tail_pointer  out  1  one-cycle pulse advancing both tails.
REQ-008 SHALL provide: comp_reset_fprint_ready  out  1  request, held until acknowledged.
REQ-009 SHALL provide: reset_fprint_ack  in  1  one-cycle acknowledge of the reset request.
REQ-010 SHALL provide: comp_mismatch_detected  out  1  mismatch qualifier for the reset request.
REQ-011 SHALL provide: ram_addr0/1  out  CRC_RAM_ADDRESS_WIDTH; ram_data0/1  in  32  fingerprint RAM read ports, 1-cycle synchronous latency.
REQ-012 SHALL provide: irq_clear  in  1; comp_irq  out  1; mismatch_task  out  CRC_KEY_WIDTH; mismatch_count  out  8.
REQ-013 SHALL size all widths via crc_defines.v macros (CRC_KEY_SIZE=16, CRC_KEY_WIDTH=4).

Function
REQ-014 SHALL implement states IDLE, SEL_WAIT, CHECK, RD, CMP, TAIL_WAIT, RESET_REQ.
REQ-015 IDLE: when any fprints_ready_in bit set, SHALL latch comp_task by round-robin starting at (last serviced task + 1) mod 16 -> SEL_WAIT; otherwise stay.
REQ-016 SEL_WAIT SHALL last 2 cycles (registered pointer reads settle) -> CHECK.
REQ-017 CHECK: tail0_matches_head0 OR tail1_matches_head1 -> RESET_REQ with mismatch flag 0; else drive ram_addr0/1 = comp_tail_pointer0/1 -> RD.
REQ-018 RD SHALL hold addresses 1 cycle -> CMP.
REQ-019 CMP: ram_data0 == ram_data1 -> pulse comp_increment_tail_pointer exactly 1 cycle -> TAIL_WAIT; else set mismatch flag -> RESET_REQ.
REQ-020 TAIL_WAIT SHALL last 2 cycles -> CHECK.
REQ-021 RESET_REQ SHALL hold comp_reset_fprint_ready=1 and comp_mismatch_detected=mismatch flag, with comp_task stable, until reset_fprint_ack=1; that cycle -> IDLE, then both deassert.
REQ-022 Ack arriving later (peer busy with set/increment) SHALL only extend RESET_REQ; no timeout.
REQ-023 On mismatch ack, SHALL set comp_irq=1 and load mismatch_task=comp_task.
REQ-024 comp_irq SHALL clear on irq_clear; a new set in the same cycle SHALL win.
REQ-025 Tail pointer wrap-around is owned by the pointer registers; this block SHALL never compute addresses other than copying tails.
REQ-026 ram_addr0/1 SHALL hold their last value outside RD/CMP.
REQ-027 reset_fprint_ack outside RESET_REQ SHALL be ignored.

Reset
REQ-028 On reset, SHALL enter IDLE; comp_task=0, last serviced=15 (first scan starts at 0), all pulses/requests=0, comp_irq=0, mismatch_task=0, mismatch_count=0, ram_addr0/1=0.
REQ-029 Reset mid-transaction SHALL abort immediately with no further increment or request pulse.

Configuration
REQ-030 With COMP_MISMATCH_COUNT_EN defined, mismatch_count SHALL increment per acknowledged mismatch, saturating at 255, cleared only by reset.
REQ-031 Without COMP_MISMATCH_COUNT_EN, mismatch_count SHALL be constant 0 with no counter logic.

Verification
REQ-032 Task 3 ready, 2 matching pairs (0xA5A5A5A5) -> two increment pulses, then reset request with mismatch=0, comp_irq stays 0.
REQ-033 Task 5 ready, data0=0x1234, data1=0x1235 -> no increment, request with mismatch=1, after ack comp_irq=1, mismatch_task=5, count=1 (macro on).
REQ-034 Tasks 2 and 9 ready, last serviced 2 -> task 9 served first, then 2.
REQ-035 Ack delayed 5 cycles -> request, comp_task, mismatch held stable all 5 cycles.
REQ-036 Reset asserted in TAIL_WAIT -> all outputs 0 next cycle, IDLE.
REQ-037 300 mismatches with macro on -> mismatch_count=255; macro off -> 0.
